// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: controller state
// encoding, default operand width and the busy-phase latency.
package div_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_LOAD = 2'b01,
      S_ITER = 2'b10,
      S_DONE = 2'b11
   } div_state_t;

   localparam int DIV_N   = 16;
   // cycles spent busy (LOAD plus N iterations) for a non-zero divisor
   localparam int DIV_LAT = DIV_N + 1;

endpackage

// File: rtl/div_controller.sv
// Divider sequencer: IDLE/LOAD/ITER/DONE state machine plus iteration counter,
// producing the datapath strobes and the registered busy/done flags.
module div_controller
   import div_pkg::*;
#(
   parameter int N  = DIV_N,
   parameter int CW = $clog2(N)
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic m_zero,
   output logic load,
   output logic shift_sub,
   output logic count_done,
   output logic capture,
   output logic dbz_capture,
   output logic busy,
   output logic done
);

   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);

   div_state_t    state_r;
   logic [CW-1:0] count_r;
   logic          busy_r;
   logic          done_r;

   assign busy = busy_r;
   assign done = done_r;

   // datapath strobes decoded from the present state
   always_comb begin
      load        = 1'b0;
      shift_sub   = 1'b0;
      count_done  = 1'b0;
      capture     = 1'b0;
      dbz_capture = 1'b0;
      case (state_r)
         S_LOAD: begin
            load        = 1'b1;
            dbz_capture = m_zero;
         end
         S_ITER: begin
            shift_sub  = 1'b1;
            count_done = (count_r == LAST_CNT);
            capture    = (count_r == LAST_CNT);
         end
         default: begin
            load = 1'b0;
         end
      endcase
   end

   // state, counter and registered status flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= S_IDLE;
         count_r <= {CW{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  state_r <= S_LOAD;
                  busy_r  <= 1'b1;
               end
            end
            S_LOAD: begin
               count_r <= {CW{1'b0}};
               if (m_zero) begin
                  state_r <= S_DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end else begin
                  state_r <= S_ITER;
               end
            end
            S_ITER: begin
               if (count_r == LAST_CNT) begin
                  state_r <= S_DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end else begin
                  count_r <= count_r + ONE_CNT;
               end
            end
            S_DONE: begin
               // start held high restarts at once, giving a one-cycle done pulse
               if (start) begin
                  state_r <= S_LOAD;
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= S_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Optional two's-complement operation is enabled by defining SIGNED_DIV_EN.
module seq_restoring_divider
   import div_pkg::*;
#(
   parameter int N  = DIV_N,
   parameter int CW = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         busy,
   output logic         done,
   output logic         div_by_zero
);

   logic         load_s;
   logic         shift_sub_s;
   logic         count_done_s;
   logic         capture_s;
   logic         dbz_capture_s;
   logic         m_zero_s;

   logic [N:0]   a_r;
   logic [N-1:0] q_r;
   logic [N-1:0] m_r;
   logic [N-1:0] quotient_r;
   logic [N-1:0] remainder_r;
   logic         dbz_r;

   logic [N:0]   a_shift_s;
   logic [N:0]   diff_s;
   logic [N:0]   a_next_s;
   logic [N-1:0] q_next_s;
   logic [N-1:0] dd_mag_s;
   logic [N-1:0] dv_mag_s;
   logic [N-1:0] q_res_s;
   logic [N-1:0] r_res_s;
   logic [N-1:0] dbz_q_s;

   assign quotient    = quotient_r;
   assign remainder   = remainder_r;
   assign div_by_zero = dbz_r;
   assign m_zero_s    = (divisor == {N{1'b0}});

   div_controller #(
      .N  (N),
      .CW (CW)
   ) u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .m_zero      (m_zero_s),
      .load        (load_s),
      .shift_sub   (shift_sub_s),
      .count_done  (count_done_s),
      .capture     (capture_s),
      .dbz_capture (dbz_capture_s),
      .busy        (busy),
      .done        (done)
   );

   // one restoring step: shift {A,Q}, trial-subtract M, keep or restore
   always_comb begin
      a_shift_s = {a_r[N-1:0], q_r[N-1]};
      diff_s    = a_shift_s - {1'b0, m_r};
      if (diff_s[N]) begin
         a_next_s = a_shift_s;
         q_next_s = {q_r[N-2:0], 1'b0};
      end else begin
         a_next_s = diff_s;
         q_next_s = {q_r[N-2:0], 1'b1};
      end
   end

`ifdef SIGNED_DIV_EN
   localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

   logic sq_r;
   logic sr_r;

   // operand magnitudes, final sign fix-up and the divide-by-zero quotient
   always_comb begin
      if (dividend[N-1]) begin
         dd_mag_s = ~dividend + ONE_N;
         dbz_q_s  = ONE_N;
      end else begin
         dd_mag_s = dividend;
         dbz_q_s  = {N{1'b1}};
      end
      if (divisor[N-1]) begin
         dv_mag_s = ~divisor + ONE_N;
      end else begin
         dv_mag_s = divisor;
      end
      if (sq_r) begin
         q_res_s = ~q_next_s + ONE_N;
      end else begin
         q_res_s = q_next_s;
      end
      if (sr_r) begin
         r_res_s = ~a_next_s[N-1:0] + ONE_N;
      end else begin
         r_res_s = a_next_s[N-1:0];
      end
   end

   // sign bits of the operation in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sq_r <= 1'b0;
         sr_r <= 1'b0;
      end else if (load_s) begin
         sq_r <= dividend[N-1] ^ divisor[N-1];
         sr_r <= dividend[N-1];
      end else begin
         sq_r <= sq_r;
         sr_r <= sr_r;
      end
   end
`else
   // unsigned operands pass straight through
   always_comb begin
      dd_mag_s = dividend;
      dv_mag_s = divisor;
      q_res_s  = q_next_s;
      r_res_s  = a_next_s[N-1:0];
      dbz_q_s  = {N{1'b1}};
   end
`endif

   // working registers A/Q/M and the registered results
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_r         <= {(N+1){1'b0}};
         q_r         <= {N{1'b0}};
         m_r         <= {N{1'b0}};
         quotient_r  <= {N{1'b0}};
         remainder_r <= {N{1'b0}};
         dbz_r       <= 1'b0;
      end else begin
         if (load_s) begin
            a_r <= {(N+1){1'b0}};
            q_r <= dd_mag_s;
            m_r <= dv_mag_s;
         end else if (shift_sub_s && !count_done_s) begin
            // the final step goes straight to the result registers
            a_r <= a_next_s;
            q_r <= q_next_s;
         end else begin
            a_r <= a_r;
            q_r <= q_r;
         end

         if (capture_s) begin
            quotient_r  <= q_res_s;
            remainder_r <= r_res_s;
            dbz_r       <= 1'b0;
         end else if (dbz_capture_s) begin
            quotient_r  <= dbz_q_s;
            remainder_r <= dividend;
            dbz_r       <= 1'b1;
         end else begin
            quotient_r  <= quotient_r;
            remainder_r <= remainder_r;
            dbz_r       <= dbz_r;
         end
      end
   end

endmodule
